// File: rtl/pc_pkg.sv
// Shared types and constants for the PC sequencer: instruction classes,
// branch funct3 encodings, trap cause codes, FSM states and flag positions.
package pc_pkg;

  localparam int unsigned TYPE_W  = 4;
  localparam int unsigned FUN3_W  = 3;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned CAUSE_W = 4;

  typedef enum logic [TYPE_W-1:0] {
    IT_LOAD   = 4'd0,
    IT_IMM    = 4'd1,
    IT_STORE  = 4'd2,
    IT_REG    = 4'd3,
    IT_LUI    = 4'd4,
    IT_AUIPC  = 4'd5,
    IT_BRANCH = 4'd6,
    IT_JALR   = 4'd7,
    IT_JAL    = 4'd8
  } inst_type_e;

  localparam logic [FUN3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [FUN3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [FUN3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [FUN3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [FUN3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [FUN3_W-1:0] F3_BGEU = 3'b111;

  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = 4'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_EXT      = 4'd11;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_TRAP = 1'b1
  } state_e;

  // Bit positions inside zcnv_flags (flags of rs1 - rs2).
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic is_legal_type(input logic [TYPE_W-1:0] t);
    return t <= TYPE_W'(IT_JAL);
  endfunction

endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// Branch condition evaluation from funct3 and the ZCNV flags of rs1 - rs2.
module branch_cond
  import pc_pkg::*;
(
  input  logic [FUN3_W-1:0] fun3_i,
  input  logic [FLAG_W-1:0] zcnv_flags_i,
  output logic              taken_c_o
);

  logic z, c, n, v;

  assign z = zcnv_flags_i[FLAG_Z];
  assign c = zcnv_flags_i[FLAG_C];
  assign n = zcnv_flags_i[FLAG_N];
  assign v = zcnv_flags_i[FLAG_V];

  // Encodings 010 and 011 are reserved and never take the branch.
  always_comb begin
    taken_c_o = 1'b0;
    case (fun3_i)
      F3_BEQ:  taken_c_o = z;
      F3_BNE:  taken_c_o = !z;
      F3_BLT:  taken_c_o = n ^ v;
      F3_BGE:  taken_c_o = !(n ^ v);
      F3_BLTU: taken_c_o = !c;
      F3_BGEU: taken_c_o = c;
      default: taken_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC holder: next-PC selection, stall, trap entry with EPC,
// mret return and retired-instruction counting.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     IALIGN       = 32,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TYPE_W-1:0]   inst_type,
  input  logic [FUN3_W-1:0]   fun3,
  input  logic [XLEN-1:0]     imm,
  input  logic [XLEN-1:0]     r,
  input  logic [FLAG_W-1:0]   zcnv_flags,
  input  logic                stall,
  input  logic                trap_req,
  input  logic                mret,
  input  logic [XLEN-1:0]     trap_vec,
  output logic [XLEN-1:0]     pc,
  output logic                pc_valid,
  output logic [XLEN-1:0]     epc,
  output logic [CAUSE_W-1:0]  cause,
  output logic [CNT_W-1:0]    retire_cnt
);

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                pc_valid_q, pc_valid_d;
  logic [XLEN-1:0]     epc_q, epc_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d;
  logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;

  logic                taken_c;
  logic [XLEN-1:0]     seq_pc_c;
  logic [XLEN-1:0]     rel_pc_c;
  logic [XLEN-1:0]     jalr_pc_c;
  logic [XLEN-1:0]     target_c;
  logic                redirect_c;
  logic                misalign_c;
  logic                illegal_c;
  logic                instr_trap_c;

  branch_cond u_branch_cond (
    .fun3_i       (fun3),
    .zcnv_flags_i (zcnv_flags),
    .taken_c_o    (taken_c)
  );

  // Target selection; only redirects are alignment-checked since pc+4 stays aligned.
  always_comb begin
    seq_pc_c   = pc_q + XLEN'(4);
    rel_pc_c   = pc_q + imm;
    jalr_pc_c  = (r + imm) & ~XLEN'(1);
    target_c   = seq_pc_c;
    redirect_c = 1'b0;
    case (inst_type)
      IT_BRANCH: begin
        if (taken_c) begin
          target_c   = rel_pc_c;
          redirect_c = 1'b1;
        end
      end
      IT_JALR: begin
        target_c   = jalr_pc_c;
        redirect_c = 1'b1;
      end
      IT_JAL: begin
        target_c   = rel_pc_c;
        redirect_c = 1'b1;
      end
      default: begin
        target_c   = seq_pc_c;
        redirect_c = 1'b0;
      end
    endcase
    misalign_c   = redirect_c && ((IALIGN == 16) ? target_c[0] : (|target_c[1:0]));
    illegal_c    = !is_legal_type(inst_type);
    instr_trap_c = illegal_c || misalign_c;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_VECTOR;
      pc_valid_q   <= 1'b1;
      epc_q        <= '0;
      cause_q      <= CAUSE_MISALIGN;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Next state: trap entry from S_RUN, unconditional single-cycle S_TRAP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (trap_req) begin
          state_d = S_TRAP;
        end else if (!mret && !stall && instr_trap_c) begin
          state_d = S_TRAP;
        end
      end
      S_TRAP:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Register updates; priority in S_RUN is trap_req > mret > stall > instruction.
  always_comb begin
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    retire_cnt_d = retire_cnt_q;
    case (state_q)
      S_RUN: begin
        if (trap_req) begin
          epc_d      = pc_q;
          cause_d    = CAUSE_EXT;
          pc_d       = trap_vec;
          pc_valid_d = 1'b0;
        end else if (mret) begin
          pc_d         = epc_q;
          retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end else if (stall) begin
          pc_d = pc_q;
        end else if (instr_trap_c) begin
          epc_d      = pc_q;
          cause_d    = illegal_c ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
          pc_d       = trap_vec;
          pc_valid_d = 1'b0;
        end else begin
          pc_d         = target_c;
          retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
      end
      S_TRAP: begin
        pc_valid_d = 1'b1;
      end
      default: begin
        pc_valid_d = 1'b1;
      end
    endcase
  end

  assign pc         = pc_q;
  assign pc_valid   = pc_valid_q;
  assign epc        = epc_q;
  assign cause      = cause_q;
  assign retire_cnt = retire_cnt_q;

endmodule
